muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit.
// Multiplies use shift-add and divides use restoring division, both one bit per cycle.
// A one-cycle fixup step then applies sign correction.
// Divide-by-zero and signed overflow can optionally bypass the iteration.
module muldiv_sequencer #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  aluSelect,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [5:0] OP_MUL    = 6'b010011;
    localparam logic [5:0] OP_MULH   = 6'b010100;
    localparam logic [5:0] OP_MULHSU = 6'b010101;
    localparam logic [5:0] OP_DIV    = 6'b010110;
    localparam logic [5:0] OP_MULHU  = 6'b010111;
    localparam logic [5:0] OP_DIVU   = 6'b011000;
    localparam logic [5:0] OP_REM    = 6'b011001;
    localparam logic [5:0] OP_REMU   = 6'b011010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_m_op(input logic [5:0] code);
        case (code)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_m_op = 1'b1;
            default:                           is_m_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [5:0] code);
        case (code)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_div_op = 1'b1;
            default:                           is_div_op = 1'b0;
        endcase
    endfunction

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic signed_a(input logic [5:0] code);
        case (code)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: signed_a = 1'b1;
            default:                             signed_a = 1'b0;
        endcase
    endfunction

    // rs2 is signed for MULH, DIV and REM (MULHSU treats it as unsigned).
    function automatic logic signed_b(input logic [5:0] code);
        case (code)
            OP_MULH, OP_DIV, OP_REM: signed_b = 1'b1;
            default:                 signed_b = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
        if (sgn && x[31]) begin
            magnitude = 32'd0 - x;
        end else begin
            magnitude = x;
        end
    endfunction

    state_t      state;
    state_t      state_next;
    logic [5:0]  op_r;
    logic [31:0] mag_a_r;
    logic [31:0] mag_b_r;
    logic        neg_a_r;
    logic        neg_b_r;
    logic        div_zero_r;
    logic [4:0]  count_r;
    logic [63:0] acc_r;
    logic [31:0] result_r;

    logic        accept_s;
    logic        in_neg_a_s;
    logic        in_neg_b_s;
    logic        in_div_zero_s;
    logic        in_ovf_s;
    logic        in_fast_s;
    logic [31:0] in_special_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic [33:0] div_diff_s;
    logic [63:0] acc_next_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] fixup_result_s;

    assign accept_s      = (state == IDLE) && start && is_m_op(aluSelect) && !flush;
    assign in_neg_a_s    = signed_a(aluSelect) && rs1[31];
    assign in_neg_b_s    = signed_b(aluSelect) && rs2[31];
    assign in_div_zero_s = is_div_op(aluSelect) && (rs2 == 32'd0);
    assign in_ovf_s      = ((aluSelect == OP_DIV) || (aluSelect == OP_REM)) &&
                           (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign in_fast_s     = FAST_SPECIAL && (in_div_zero_s || in_ovf_s);

    // Result for the special cases that skip iteration.
    always_comb begin
        in_special_s = 32'd0;
        if (in_div_zero_s) begin
            if ((aluSelect == OP_REM) || (aluSelect == OP_REMU)) begin
                in_special_s = rs1;
            end else begin
                in_special_s = 32'hFFFF_FFFF;
            end
        end else begin
            if (aluSelect == OP_REM) begin
                in_special_s = 32'd0;
            end else begin
                in_special_s = 32'h8000_0000;
            end
        end
    end

    // One iteration step: shift-add for multiply, restore-subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, mag_a_r} : 33'd0);
        div_shift_s = {acc_r[63:32], acc_r[31]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, mag_b_r};
        if (is_div_op(op_r)) begin
            if (div_diff_s[33]) begin
                acc_next_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
            end else begin
                acc_next_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[31:1]};
        end
    end

    // Sign correction and result selection performed in FIXUP.
    always_comb begin
        if (neg_a_r ^ neg_b_r) begin
            prod_s = 64'd0 - acc_r;
        end else begin
            prod_s = acc_r;
        end
        if (div_zero_r) begin
            quot_s = 32'hFFFF_FFFF;
        end else if (neg_a_r ^ neg_b_r) begin
            quot_s = 32'd0 - acc_r[31:0];
        end else begin
            quot_s = acc_r[31:0];
        end
        if (neg_a_r) begin
            rem_s = 32'd0 - acc_r[63:32];
        end else begin
            rem_s = acc_r[63:32];
        end
        case (op_r)
            OP_MUL:                       fixup_result_s = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixup_result_s = prod_s[63:32];
            OP_DIV, OP_DIVU:              fixup_result_s = quot_s;
            OP_REM, OP_REMU:              fixup_result_s = rem_s;
            default:                      fixup_result_s = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush wins over everything but reset.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_s) begin
                        state_next = in_fast_s ? DONE : CALC;
                    end else begin
                        state_next = IDLE;
                    end
                end
                CALC: begin
                    if (count_r == 5'd31) begin
                        state_next = FIXUP;
                    end else begin
                        state_next = CALC;
                    end
                end
                FIXUP:   state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_r       <= 6'd0;
            mag_a_r    <= 32'd0;
            mag_b_r    <= 32'd0;
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            div_zero_r <= 1'b0;
            count_r    <= 5'd0;
            acc_r      <= 64'd0;
            result_r   <= 32'd0;
        end else if (accept_s) begin
            op_r       <= aluSelect;
            mag_a_r    <= magnitude(rs1, signed_a(aluSelect));
            mag_b_r    <= magnitude(rs2, signed_b(aluSelect));
            neg_a_r    <= in_neg_a_s;
            neg_b_r    <= in_neg_b_s;
            div_zero_r <= in_div_zero_s;
            count_r    <= 5'd0;
            if (is_div_op(aluSelect)) begin
                acc_r <= {32'd0, magnitude(rs1, signed_a(aluSelect))};
            end else begin
                acc_r <= {32'd0, magnitude(rs2, signed_b(aluSelect))};
            end
            if (in_fast_s) begin
                result_r <= in_special_s;
            end
        end else if ((state == CALC) && !flush) begin
            acc_r   <= acc_next_s;
            count_r <= count_r + 5'd1;
        end else if ((state == FIXUP) && !flush) begin
            result_r <= fixup_result_s;
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign stall  = (busy && !done) || accept_s;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer using an expected-result queue.
module tb_muldiv_sequencer;

    localparam logic [5:0] OP_MUL    = 6'b010011;
    localparam logic [5:0] OP_MULH   = 6'b010100;
    localparam logic [5:0] OP_MULHSU = 6'b010101;
    localparam logic [5:0] OP_DIV    = 6'b010110;
    localparam logic [5:0] OP_MULHU  = 6'b010111;
    localparam logic [5:0] OP_DIVU   = 6'b011000;
    localparam logic [5:0] OP_REM    = 6'b011001;
    localparam logic [5:0] OP_REMU   = 6'b011010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  aluSelect;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .aluSelect (aluSelect),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .result    (result)
    );

    // Reference arithmetic in RV32M semantics.
    function automatic logic [31:0] ref_model(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      ps;
        logic [63:0] pu;
        sa = a;
        sb = b;
        ref_model = 32'd0;
        case (code)
            OP_MUL: begin
                pu = {32'd0, a} * {32'd0, b};
                ref_model = pu[31:0];
            end
            OP_MULH: begin
                ps = longint'(sa) * longint'(sb);
                pu = ps;
                ref_model = pu[63:32];
            end
            OP_MULHSU: begin
                ps = longint'(sa) * longint'({32'd0, b});
                pu = ps;
                ref_model = pu[63:32];
            end
            OP_MULHU: begin
                pu = {32'd0, a} * {32'd0, b};
                ref_model = pu[63:32];
            end
            OP_DIV: begin
                if (b == 32'd0) ref_model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = 32'h8000_0000;
                else ref_model = sa / sb;
            end
            OP_REM: begin
                if (b == 32'd0) ref_model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = 32'd0;
                else ref_model = sa % sb;
            end
            OP_DIVU: ref_model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: ref_model = (b == 32'd0) ? a : a % b;
            default: ref_model = 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        logic is_div;
        logic is_sdiv;
        is_div  = (code == OP_DIV) || (code == OP_DIVU) || (code == OP_REM) || (code == OP_REMU);
        is_sdiv = (code == OP_DIV) || (code == OP_REM);
        if (is_div && b == 32'd0) ref_latency = 1;
        else if (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_latency = 1;
        else ref_latency = 34;
    endfunction

    // Issue one op at a negedge in IDLE and follow it to completion.
    task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string name);
        int          edges;
        int          lat;
        logic        seen;
        logic [31:0] e;
        lat = ref_latency(code, a, b);
        aluSelect = code;
        rs1 = a;
        rs2 = b;
        start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL %s stall_on_request got=%b want=1", name, stall);
        end
        exp_q.push_back(exp_res);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        aluSelect = 6'($urandom);
        rs1 = $urandom;
        rs2 = $urandom;
        seen = 1'b0;
        while (!seen && edges < 100) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                total++;
                if (stall !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_stall edge=%0d got busy=%b stall=%b want 1,1", name, edges, busy, stall);
                end
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        e = exp_q.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s done_timeout got=none want=done within 100 edges", name);
        end else begin
            total++;
            if (edges != lat) begin
                bad++;
                $display("FAIL %s latency got=%0d want=%0d", name, edges, lat);
            end
            total++;
            if (result !== e) begin
                bad++;
                $display("FAIL %s result got=%h want=%h", name, result, e);
            end
            total++;
            if (stall !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL %s done_cycle got busy=%b stall=%b want 1,0", name, busy, stall);
            end
        end
        last_exp = e;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== e) begin
            bad++;
            $display("FAIL %s after_done got done=%b busy=%b result=%h want 0,0,%h", name, done, busy, result, e);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        aluSelect = 6'd0;
        rs1 = 32'd0;
        rs2 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
            bad++;
            $display("FAIL reset got busy=%b done=%b stall=%b result=%h want all zero", busy, done, stall, result);
        end
        reset_n = 1'b1;
        last_exp = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_mul;
        run_op(OP_MUL, 32'd2, 32'd4, 32'h0000_0008, "mul_2x4");
    endtask

    task automatic test_div_rem;
        run_op(OP_DIV, 32'd8, 32'd2, 32'h0000_0004, "div_8_2");
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    endtask

    task automatic test_special;
        run_op(OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
        run_op(OP_REMU, 32'd7, 32'd0, 32'h0000_0007, "remu_by_zero");
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_neg_by_zero");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow");
    endtask

    task automatic test_mulh;
        run_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1");
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu_m1_2");
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "divu_no_overflow");
    endtask

    task automatic test_back_to_back;
        logic [5:0]  codes [8];
        logic [5:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        codes = '{OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_MULHU, OP_DIVU, OP_REM, OP_REMU};
        for (int i = 0; i < 8; i++) begin
            c = codes[i];
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 3) a = 32'hFFFF_8000;
            run_op(c, a, b, ref_model(c, a, b), "b2b_random");
        end
    endtask

    task automatic test_flush;
        logic [31:0] held;
        held = last_exp;
        flush = 1'b1;
        start = 1'b1;
        aluSelect = OP_MUL;
        rs1 = 32'd3;
        rs2 = 32'd3;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_over_start stall got=%b want=0", stall);
        end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_over_start busy got=%b want=0", busy);
        end
        aluSelect = OP_DIVU;
        rs1 = 32'd1000;
        rs2 = 32'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL flush_pre_done got=%b want=0", done);
            end
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== held) begin
            bad++;
            $display("FAIL flush_abort got busy=%b done=%b result=%h want 0,0,%h", busy, done, result, held);
        end
        run_op(OP_DIVU, 32'd1000, 32'd7, 32'd142, "after_flush");
    endtask

    task automatic test_reset_mid;
        aluSelect = OP_MUL;
        rs1 = 32'd12345;
        rs2 = 32'd678;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid got busy=%b done=%b stall=%b result=%h want all zero", busy, done, stall, result);
        end
        reset_n = 1'b1;
        last_exp = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_non_m;
        aluSelect = 6'b000101;
        rs1 = 32'd5;
        rs2 = 32'd6;
        start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL non_m_stall got=%b want=0", stall);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL non_m_ignored got busy=%b done=%b want 0,0", busy, done);
        end
        run_op(OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, "mul_after_non_m");
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div_rem;
        test_special;
        test_mulh;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_non_m;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
